// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one full-adder cell plus carry flop, LSB first.
// Optional subtract mode (a - b, two's complement) enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, busy_q, done_q;
  logic             fa_s, fa_c;
  logic [WIDTH-1:0] load_b;
  logic             load_carry;

  always_comb begin
    fa_s     = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    fa_c     = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
    sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
  end

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract is a + ~b + 1; cin is deliberately dropped in that mode.
  assign load_b     = sub ? ~b : b;
  assign load_carry = sub ? 1'b1 : cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign load_b     = b;
  assign load_carry = cin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= load_b;
            carry_q <= load_carry;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_sr_q   <= {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_q   <= {1'b0, b_sr_q[WIDTH-1:1]};
          carry_q  <= fa_c;
          sum_sr_q <= sum_sr_d;
          cnt_q    <= cnt_q + CW'(1);
          // Result registers only move on the final bit so partial sums never leak out.
          if (cnt_q == CW'(WIDTH - 1)) begin
            sum_q   <= sum_sr_d;
            cout_q  <= fa_c;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder (WIDTH=8 directed, WIDTH=2 exhaustive).
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       start2 = 1'b0, cin2 = 1'b0, sub2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;

  logic [8:0] q8[$];
  logic [2:0] q2[$];
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2), .sub(sub2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && done8 === 1'b1) begin
      if (q8.size() == 0) check("sb8_unexpected_done", 32'd1, 32'd0);
      else check("sb8_result", {23'd0, cout8, sum8}, {23'd0, q8.pop_front()});
    end
    if (rst_n && done2 === 1'b1) begin
      if (q2.size() == 0) check("sb2_unexpected_done", 32'd1, 32'd0);
      else check("sb2_result", {29'd0, cout2, sum2}, {29'd0, q2.pop_front()});
    end
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                        input logic [8:0] exp);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; sub8 = s; start8 = 1'b1;
    q8.push_back(exp);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_done8(input string name);
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done8) begin seen = 1; break; end
    end
    if (!seen) check(name, 32'd0, 32'd1);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                     input logic [8:0] exp, input string name);
    issue8(a, b, c, s, exp);
    wait_done8(name);
  endtask

  initial begin
    int busy_cnt, done_cnt, done_at, d1, d2;
    bit seen;

    repeat (3) @(negedge clk);
    check("reset_busy", busy8, 0);
    check("reset_done", done8, 0);
    check("reset_sum", sum8, 0);
    check("reset_cout", cout8, 0);
    rst_n = 1'b1;

    // Basic add with latency and busy-width measurement
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h096);
    @(posedge clk);
    #1 start8 = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy8) busy_cnt++;
      if (done8) begin done_cnt++; if (done_at < 0) done_at = i; end
    end
    check("basic_busy_cycles", busy_cnt, 8);
    check("basic_done_cycles", done_cnt, 1);
    check("basic_done_latency", done_at, 8);
    check("basic_sum_held", sum8, 8'h96);

    op8(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, "to_ff_01");
    op8(8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF, "to_ff_ff");
    op8(8'h00, 8'h00, 1'b1, 1'b0, 9'h001, "to_00_00");

    // Reset three cycles into a run
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_sum", sum8, 0);
    check("abort_cout", cout8, 0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) done_cnt++;
      if (i == 2) rst_n = 1'b1;
    end
    check("abort_no_done", done_cnt, 0);
    op8(8'h01, 8'h01, 1'b0, 1'b0, 9'h002, "to_post_reset");

    // Start held high across RUN with operands changed mid-run
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h046);
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h81; cin8 = 1'b1;
    q8.push_back(9'h102);
    d1 = -1; d2 = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done8 && d1 < 0) begin
        d1 = i;
        check("hs_busy_low_in_done", busy8, 0);
      end else if (done8 && d2 < 0) d2 = i;
      if (d1 >= 0 && i == d1 + 1) begin
        start8 = 1'b0;
        check("hs_restarted_from_done", busy8, 1);
      end
    end
    check("hs_first_done_seen", (d1 >= 0), 1);
    check("hs_period", d2 - d1, 9);

`ifdef SERIAL_ADDER_SUB_EN
    op8(8'h10, 8'h01, 1'b0, 1'b1, 9'h10F, "to_sub_10_01");
    op8(8'h01, 8'h02, 1'b0, 1'b1, 9'h0FF, "to_sub_01_02");
`else
    op8(8'h10, 8'h01, 1'b0, 1'b1, 9'h011, "to_sub_ignored");
`endif
    repeat (5) @(negedge clk);
`ifdef SERIAL_ADDER_SUB_EN
    check("sum_held_idle", {cout8, sum8}, 9'h0FF);
`else
    check("sum_held_idle", {cout8, sum8}, 9'h011);
`endif

    // Exhaustive WIDTH=2
    for (int i = 0; i < 32; i++) begin
      logic [1:0] ta, tb;
      logic tc;
      logic [2:0] e;
      ta = i[4:3]; tb = i[2:1]; tc = i[0];
      e = {1'b0, ta} + {1'b0, tb} + {2'b00, tc};
      @(negedge clk);
      a2 = ta; b2 = tb; cin2 = tc; start2 = 1'b1;
      q2.push_back(e);
      @(negedge clk);
      start2 = 1'b0;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (done2) begin seen = 1; break; end
      end
      if (!seen) check("to_w2", 32'd0, 32'd1);
    end

    repeat (3) @(negedge clk);
    check("sb8_drained", q8.size(), 0);
    check("sb2_drained", q2.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
